// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array front end: instruction opcodes and
// scheduler state encoding.
package sa_pkg;

   typedef enum logic [4:0] {
      OP_NOP       = 5'd0,
      OP_COMPUTE   = 5'd1,
      OP_COMPUTE_I = 5'd2,
      OP_ACC_TO_OB = 5'd3,
      OP_LD_INP    = 5'd4,
      OP_LD_WT     = 5'd5,
      OP_OB_SEND   = 5'd6,
      OP_ACC_RST   = 5'd7,
      OP_HALT      = 5'd31
   } opcode_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      CWAIT  = 2'd1,
      HALTED = 2'd2
   } sched_state_t;

   function automatic logic is_compute(input logic [4:0] op);
      return (op == OP_COMPUTE) || (op == OP_COMPUTE_I);
   endfunction

endpackage

// File: rtl/instr_scheduler_if.sv
// Host-side instruction bus and controller-side issue/status signals of the
// instruction scheduler.
interface instr_scheduler_if #(
   parameter int INSTR_W = 64,
   parameter int DEPTH   = 8
);
   logic [INSTR_W-1:0]      host_instr;
   logic                    host_valid;
   logic                    host_ready;
   logic                    flush;
   logic                    resume;
   logic [INSTR_W-1:0]      issue_instr;
   logic                    issue_valid;
   logic                    halted;
   logic                    busy;
   logic [$clog2(DEPTH):0]  fifo_count;

   modport master (
      output host_instr, host_valid, flush, resume,
      input  host_ready, issue_instr, issue_valid, halted, busy, fifo_count
   );

   modport slave (
      input  host_instr, host_valid, flush, resume,
      output host_ready, issue_instr, issue_valid, halted, busy, fifo_count
   );
endinterface

// File: rtl/instr_fifo.sv
// Instruction queue: circular buffer with an occupancy count so full and empty
// are distinguishable; head is valid combinationally whenever not empty.
module instr_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];
   assign count   = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; only the pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/instr_scheduler.sv
// Issue scheduler in front of the systolic-array controller: pops the queue one
// instruction per cycle, holds off during COMPUTE, and parks on HALT until resume.
module instr_scheduler
   import sa_pkg::*;
#(
   parameter int INSTR_W        = 64,
   parameter int DEPTH          = 8,
   parameter int COMPUTE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_scheduler_if.slave  bus
);
   localparam int WAIT_W = $clog2(COMPUTE_CYCLES + 1);

   logic [INSTR_W-1:0]      head;
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;

   sched_state_t            state_q, state_d;
   logic [WAIT_W-1:0]       cnt_q, cnt_d;
   logic [INSTR_W-1:0]      issue_instr_p0, issue_instr_d;
   logic                    vld_p0, vld_d;

   assign bus.host_ready = ~full & ~bus.flush;
   assign push           = bus.host_valid & bus.host_ready;

   instr_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (bus.flush),
      .din   (bus.host_instr),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pop           = 1'b0;
      issue_instr_d = '0;
      vld_d         = 1'b0;
      case (state_q)
         RUN: begin
            if (!empty && !bus.flush) begin
               pop = 1'b1;
               if (head[4:0] == OP_HALT) begin
                  state_d = HALTED;
               end else begin
                  issue_instr_d = head;
                  vld_d         = 1'b1;
                  if (is_compute(head[4:0])) begin
                     cnt_d   = WAIT_W'(COMPUTE_CYCLES);
                     state_d = CWAIT;
                  end
               end
            end
         end
         // The array cannot be stopped, so flush never shortens this wait.
         CWAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == WAIT_W'(1)) state_d = RUN;
         end
         HALTED: begin
            if (bus.resume) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Stage p0: registered issue port and scheduler state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         cnt_q          <= '0;
         issue_instr_p0 <= '0;
         vld_p0         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         issue_instr_p0 <= issue_instr_d;
         vld_p0         <= vld_d;
      end
   end

   assign bus.issue_instr = issue_instr_p0;
   assign bus.issue_valid = vld_p0;
   assign bus.halted      = (state_q == HALTED);
   assign bus.busy        = (state_q != RUN) | (count != '0);
   assign bus.fifo_count  = count;
endmodule

// File: tb/tb_instr_scheduler.sv
// Randomized and directed bench for instr_scheduler against a queue-based
// reference model of the issue rules.
module tb_instr_scheduler;
   localparam int INSTR_W = 64;
   localparam int DEPTH   = 8;
   localparam int CC      = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_scheduler_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

   instr_scheduler #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .COMPUTE_CYCLES(CC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: queue contents, halt flag, and the earliest edge at which
   // the array is free again after a COMPUTE.
   logic [63:0] mq[$];
   bit          m_halted;
   longint      edge_n;
   longint      free_edge;
   int          total = 0;
   int          bad   = 0;

   localparam logic [63:0] I_CMP  = 64'h0000_C0DE_0000_0001;
   localparam logic [63:0] I_LDI  = 64'h0000_A1A1_0000_0004;
   localparam logic [63:0] I_LDW  = 64'h0000_B2B2_0000_0005;
   localparam logic [63:0] I_ARST = 64'h0000_C3C3_0000_0007;
   localparam logic [63:0] I_HALT = 64'h0000_DEAD_0000_001F;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_halted  = 0;
      edge_n    = 0;
      free_edge = 0;
   endtask

   // One clock: drive inputs, predict, then compare every output after the edge.
   task automatic cycle(input logic v, input logic [63:0] ins, input logic fl,
                        input logic rs, output logic acc);
      logic        m_ready;
      logic [63:0] h;
      logic [63:0] exp_instr;
      logic        exp_valid;
      bit          popped_halt;
      logic        exp_busy;
      @(negedge clk);
      bus.host_valid = v;
      bus.host_instr = ins;
      bus.flush      = fl;
      bus.resume     = rs;
      #1;
      m_ready = (mq.size() < DEPTH) && !fl;
      chk("host_ready", {63'd0, bus.host_ready}, {63'd0, m_ready});
      acc = v && m_ready;

      edge_n++;
      exp_instr   = '0;
      exp_valid   = 1'b0;
      popped_halt = 0;
      if (!m_halted && edge_n >= free_edge && mq.size() > 0 && !fl) begin
         h = mq.pop_front();
         if (h[4:0] == 5'd31) popped_halt = 1;
         else begin
            exp_instr = h;
            exp_valid = 1'b1;
            if (h[4:0] == 5'd1 || h[4:0] == 5'd2) free_edge = edge_n + CC + 1;
         end
      end
      if (m_halted) m_halted = !rs;
      else          m_halted = popped_halt;
      if (fl)  mq.delete();
      if (acc) mq.push_back(ins);
      exp_busy = m_halted || (edge_n + 1 < free_edge) || (mq.size() != 0);

      @(posedge clk);
      #1;
      chk("issue_instr", bus.issue_instr, exp_instr);
      chk("issue_valid", {63'd0, bus.issue_valid}, {63'd0, exp_valid});
      chk("halted", {63'd0, bus.halted}, {63'd0, m_halted});
      chk("busy", {63'd0, bus.busy}, {63'd0, exp_busy});
      chk("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.host_valid = 1'b0;
      bus.flush      = 1'b0;
      bus.resume     = 1'b0;
      #1;
      chk("rst_issue_instr", bus.issue_instr, 64'd0);
      chk("rst_issue_valid", {63'd0, bus.issue_valid}, 64'd0);
      chk("rst_halted", {63'd0, bus.halted}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
      chk("rst_host_ready", {63'd0, bus.host_ready}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   initial begin
      logic        acc;
      int          n, k, vcnt, c_cmp, c_ldi;
      logic        pend_v;
      logic [63:0] pend_i;
      logic        fl, rs;

      rst_n          = 1'b0;
      bus.host_valid = 1'b0;
      bus.host_instr = '0;
      bus.flush      = 1'b0;
      bus.resume     = 1'b0;
      model_clear();
      do_reset();

      // Back-to-back issue of three plain instructions
      cycle(1, I_LDI, 0, 0, acc);
      chk("t2_nop_first", {63'd0, bus.issue_valid}, 64'd0);
      cycle(1, I_LDW, 0, 0, acc);
      chk("t2_issue1", bus.issue_instr, I_LDI);
      cycle(1, I_ARST, 0, 0, acc);
      chk("t2_issue2", bus.issue_instr, I_LDW);
      cycle(0, '0, 0, 0, acc);
      chk("t2_issue3", bus.issue_instr, I_ARST);
      cycle(0, '0, 0, 0, acc);
      chk("t2_idle", bus.issue_instr, 64'd0);

      // COMPUTE spacing
      cycle(1, I_CMP, 0, 0, acc);
      cycle(1, I_LDI, 0, 0, acc);
      c_cmp = -1; c_ldi = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.issue_valid && bus.issue_instr == I_CMP) c_cmp = i;
         if (bus.issue_valid && bus.issue_instr == I_LDI) c_ldi = i;
         cycle(0, '0, 0, 0, acc);
      end
      chk("t3_spacing", 64'(c_ldi - c_cmp), 64'd17);

      // Fill the queue during CWAIT with a host that holds its 9th instruction
      cycle(1, I_CMP, 0, 0, acc);
      cycle(0, '0, 0, 0, acc);
      n = 0; k = 0;
      while (n < 9 && k < 60) begin
         cycle(1, I_LDI | (64'(n) << 32), 0, 0, acc);
         if (acc) begin
            n++;
            if (n == 8) begin
               chk("t4_full_count", 64'(bus.fifo_count), 64'd8);
               chk("t4_ready_low", {63'd0, bus.host_ready}, 64'd0);
            end
         end
         k++;
      end
      chk("t4_ninth_accepted", 64'(n), 64'd9);
      k = 0;
      while (bus.busy && k < 100) begin cycle(0, '0, 0, 0, acc); k++; end
      chk("t4_drained", {63'd0, bus.busy}, 64'd0);

      // HALT then resume
      cycle(1, I_HALT, 0, 0, acc);
      cycle(1, I_LDW, 0, 0, acc);
      vcnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, '0, 0, 0, acc);
         if (bus.issue_valid) vcnt++;
      end
      chk("t5_no_issue", 64'(vcnt), 64'd0);
      chk("t5_halted", {63'd0, bus.halted}, 64'd1);
      cycle(0, '0, 0, 1, acc);
      chk("t5_resume_nop", {63'd0, bus.issue_valid}, 64'd0);
      cycle(0, '0, 0, 0, acc);
      chk("t5_ldw_issued", bus.issue_instr, I_LDW);

      // Flush during CWAIT with a simultaneous push
      cycle(1, I_CMP, 0, 0, acc);
      cycle(1, I_LDI, 0, 0, acc);
      cycle(1, I_LDW, 0, 0, acc);
      cycle(1, I_ARST, 0, 0, acc);
      cycle(1, I_LDI, 1, 0, acc);
      chk("t6_flushed", 64'(bus.fifo_count), 64'd0);
      vcnt = 0; k = 0;
      while (bus.busy && k < 40) begin
         cycle(0, '0, 0, 0, acc);
         if (bus.issue_valid) vcnt++;
         k++;
      end
      chk("t6_cwait_len", 64'(k), 64'd13);
      chk("t6_no_issue", 64'(vcnt), 64'd0);

      // Randomized traffic with a host that holds each instruction until accepted
      pend_v = 1'b0;
      pend_i = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!pend_v && ($urandom_range(0, 9) < 7)) begin
            pend_v = 1'b1;
            pend_i = {$urandom, $urandom};
            case ($urandom_range(0, 19))
               0:       pend_i[4:0] = 5'd31;
               1, 2:    pend_i[4:0] = 5'd1;
               3:       pend_i[4:0] = 5'd2;
               default: pend_i[4:0] = 5'($urandom_range(0, 30));
            endcase
         end
         fl = ($urandom_range(0, 99) < 3);
         rs = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
         cycle(pend_v, pend_i, fl, rs, acc);
         if (acc) pend_v = 1'b0;
         if (i == 1500) begin
            do_reset();
            pend_v = 1'b0;
         end
      end

      // Reset with traffic queued
      cycle(1, I_HALT, 0, 0, acc);
      cycle(1, I_LDI, 0, 0, acc);
      cycle(1, I_LDW, 0, 0, acc);
      do_reset();
      cycle(0, '0, 0, 0, acc);
      chk("post_rst_idle", {63'd0, bus.issue_valid}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
